// File: rtl/gpio_slave_arbiter.sv
// gpio_slave_arbiter
// Round-robin arbiter that shares the single Avalon-MM slave port of the
// 4-bit GPIO peripheral between NUM_REQ masters. Each accepted transfer
// produces exactly one chipselect cycle. Read data from the GPIO (registered,
// one cycle behind its address) is returned to the issuing master with a
// one-cycle readdatavalid pulse.
// Optional build macro GPIO_ARB_LOCK_EN adds a req_lock input that lets one
// master hold the grant across several transfers (atomic read-modify-write).
module gpio_slave_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_chipselect,
    input  logic [NUM_REQ-1:0]          req_write_n,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [NUM_REQ-1:0]          req_readdatavalid,
    output logic [DATA_W-1:0]           req_readdata,
    output logic                        gpio_chipselect,
    output logic                        gpio_write_n,
    output logic [ADDR_W-1:0]           gpio_address,
    output logic [DATA_W-1:0]           gpio_writedata,
    input  logic [DATA_W-1:0]           gpio_readdata
`ifdef GPIO_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]          req_lock
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]   grant_reg;
    logic [NUM_REQ-1:0] grant_onehot;
    logic               gpio_write_n_reg;
    logic [ADDR_W-1:0]  gpio_address_reg;
    logic [DATA_W-1:0]  gpio_writedata_reg;
    logic [NUM_REQ-1:0] readdatavalid_reg;
    logic [DATA_W-1:0]  readdata_reg;

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   winner;
    logic               winner_valid;
    logic               accept;
    logic [IDX_W:0]     idx_sum;
    logic [IDX_W:0]     winner_inc;

`ifdef GPIO_ARB_LOCK_EN
    logic               lock_active_reg;
    logic [IDX_W-1:0]   lock_owner_reg;
    logic [NUM_REQ-1:0] owner_mask;

    // While locked, only the lock owner may compete for the grant
    always_comb eligible = lock_active_reg ? (req_chipselect & owner_mask) : req_chipselect;
`else
    // Pure round-robin: every requester competes
    always_comb eligible = req_chipselect;
`endif

    // Pick the first eligible requester scanning upward from rr_ptr, wrapping
    always_comb begin
        winner       = rr_ptr_reg;
        winner_valid = 1'b0;
        idx_sum      = '0;
        // Scan from the far end so the lowest offset from rr_ptr wins last
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (idx_sum >= NUM_REQ_W) begin
                idx_sum = idx_sum - NUM_REQ_W;
            end
            if (eligible[idx_sum[IDX_W-1:0]]) begin
                winner       = idx_sum[IDX_W-1:0];
                winner_valid = 1'b1;
            end
        end
    end

    // Acceptance happens only in IDLE and never while reset is asserted
    assign accept = (state_reg == ST_IDLE) && winner_valid && !reset;

    // Priority moves to the master after the winner; during a lock the winner
    // is always the owner, so this value stays put until the lock is released
    always_comb begin
        winner_inc  = {1'b0, winner} + (IDX_W+1)'(1);
        rr_ptr_next = rr_ptr_reg;
        if (accept) begin
            rr_ptr_next = (winner_inc == NUM_REQ_W) ? '0 : winner_inc[IDX_W-1:0];
        end
    end

    // Per-master decode of the grant and the acceptance strobe
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_waitrequest[gi] = !(accept && (winner == IDX_W'(gi)));
            assign grant_onehot[gi]    = (grant_reg == IDX_W'(gi));
`ifdef GPIO_ARB_LOCK_EN
            assign owner_mask[gi]      = (lock_owner_reg == IDX_W'(gi));
`endif
        end
    endgenerate

    // IDLE -> ISSUE on acceptance; ISSUE -> RESP for reads, IDLE for writes
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_ISSUE;
            ST_ISSUE: state_next = gpio_write_n_reg ? ST_RESP : ST_IDLE;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, priority pointer, latched command fields and read return path
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            rr_ptr_reg         <= '0;
            grant_reg          <= '0;
            gpio_write_n_reg   <= 1'b1;
            gpio_address_reg   <= '0;
            gpio_writedata_reg <= '0;
            readdatavalid_reg  <= '0;
            readdata_reg       <= '0;
        end else begin
            state_reg         <= state_next;
            rr_ptr_reg        <= rr_ptr_next;
            readdatavalid_reg <= '0;
            if (accept) begin
                grant_reg          <= winner;
                gpio_write_n_reg   <= req_write_n[winner];
                gpio_address_reg   <= req_address[winner*ADDR_W +: ADDR_W];
                gpio_writedata_reg <= req_writedata[winner*DATA_W +: DATA_W];
            end
            if (state_reg == ST_RESP) begin
                readdata_reg      <= gpio_readdata;
                readdatavalid_reg <= grant_onehot;
            end
        end
    end

`ifdef GPIO_ARB_LOCK_EN
    // Lock starts when the winner asks for it and ends on the owner's next
    // accepted transfer without req_lock
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_active_reg <= 1'b0;
            lock_owner_reg  <= '0;
        end else if (accept) begin
            if (lock_active_reg) begin
                if (!req_lock[winner]) begin
                    lock_active_reg <= 1'b0;
                end
            end else if (req_lock[winner]) begin
                lock_active_reg <= 1'b1;
                lock_owner_reg  <= winner;
            end
        end
    end
`endif

    // Chipselect is a pure decode of ISSUE, so it can never span two cycles
    assign gpio_chipselect   = (state_reg == ST_ISSUE);
    assign gpio_write_n      = gpio_write_n_reg;
    assign gpio_address      = gpio_address_reg;
    assign gpio_writedata    = gpio_writedata_reg;
    assign req_readdatavalid = readdatavalid_reg;
    assign req_readdata      = readdata_reg;

endmodule

// File: doc/gpio_slave_arbiter.md
Name: gpio_slave_arbiter

Overview:
- Shares the single Avalon-MM slave port of the 4-bit bidirectional GPIO peripheral between NUM_REQ masters, e.g. the Nios CPU and the hardware temperature/fan sequencer.
- Round-robin arbitration, one transfer per grant.
- Issues exactly one chipselect cycle per accepted transfer and routes the GPIO's 1-cycle registered readdata back to the issuing master with a readdatavalid pulse.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..8)
- ADDR_W, 3, GPIO register address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- req_chipselect  in  NUM_REQ  per-master transfer request
- req_write_n  in  NUM_REQ  per-master 0=write, 1=read
- req_address  in  NUM_REQ*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
- req_writedata  in  NUM_REQ*DATA_W  per-master write data, same packing
- req_waitrequest  out  NUM_REQ  per-master stall; transfer accepted when chipselect=1 and waitrequest=0
- req_readdatavalid  out  NUM_REQ  one-cycle pulse to the master whose read is returning
- req_readdata  out  DATA_W  shared read return bus
- gpio_chipselect  out  1  to GPIO chipselect
- gpio_write_n  out  1  to GPIO write_n
- gpio_address  out  ADDR_W  to GPIO address
- gpio_writedata  out  DATA_W  to GPIO writedata
- gpio_readdata  in  DATA_W  from GPIO; reflects the address of the previous cycle

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- States are IDLE, ISSUE and RESP. Reset state is IDLE.
- Reset values:
  - gpio_chipselect=0, gpio_write_n=1, gpio_address=0, gpio_writedata=0.
  - req_readdatavalid=0, req_readdata=0.
  - req_waitrequest all 1.
  - rr_ptr=0 (rr_ptr is the highest-priority index).
- IDLE:
  - Winner = first i with req_chipselect[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_waitrequest[winner]=0 combinationally in this cycle; all others stay 1. This is the acceptance cycle.
  - Command fields are registered into the gpio_* outputs and the winner index into grant. Next state is ISSUE.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - No request: stay in IDLE, all waitrequest=1.
- ISSUE:
  - gpio_chipselect=1 for exactly this one cycle, with the registered fields. All req_waitrequest=1.
  - Write: next state IDLE.
  - Read: next state RESP.
- RESP:
  - req_readdata <= gpio_readdata, registered at the RESP edge.
  - req_readdatavalid[grant] pulses 1 for the following cycle.
  - gpio_chipselect=0, all waitrequest=1. Next state IDLE.
- Latency:
  - Write: accepted cycle 0, GPIO write strobe cycle 1; next acceptance possible cycle 2.
  - Read: accepted cycle 0, chipselect cycle 1, readdatavalid cycle 3; next acceptance possible cycle 3.
  - readdatavalid may coincide with the next acceptance.
- gpio_chipselect is never high on two consecutive cycles.
- gpio_address is held unchanged from ISSUE through RESP.
- Master rules:
  - A master that drops chipselect while stalled has not been accepted. Its fields are never latched.
  - Commands from non-winners are ignored that cycle.
- Reset mid-operation: return to IDLE next edge. Any pending read is dropped with no readdatavalid. An in-flight ISSUE cycle coincident with reset still drives chipselect in that cycle only.
- Addresses and data pass through unmodified: no decode, no width change. Set/clear semantics (addresses 4 and 5) are left to the GPIO.

Optional Feature:
- Macro: GPIO_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NUM_REQ].
  - If the granted master's req_lock=1 at acceptance, the arbiter enters a locked condition. In IDLE only that master can win, even if others are requesting, and rr_ptr is frozen.
  - Lock ends at the next accepted transfer of that master with req_lock=0. Round-robin then resumes from (lock_owner+1).
  - Intended for atomic read-modify-write of data_dir.
  - Reset clears lock.
- Undefined: no req_lock port. Pure round-robin.

Test Plan:
- Single write: master 0 writes addr 0, data 0x5 -> waitrequest0 low cycle 0; gpio_chipselect=1, gpio_write_n=0, gpio_address=0, gpio_writedata=0x5 in cycle 1 only.
- Single read: master 1 reads addr 1 while GPIO returns 0xA -> readdatavalid[1] pulses once in cycle 3 with req_readdata=0xA; readdatavalid[0] stays 0.
- Contention: both masters continuously write from reset -> grants alternate 0,1,0,1; chipselect never high on consecutive cycles; 4 writes complete in 8 cycles.
- Back-to-back reads: master 0 issues 3 reads (addr 0,1,0) -> readdatavalid on cycles 3,6,9, each carrying gpio_readdata for the matching address.
- Reset mid-read: reset asserted during RESP -> no readdatavalid; all waitrequest=1 and gpio_chipselect=0 the next cycle; rr_ptr=0.
- Lock (GPIO_ARB_LOCK_EN): master 1 reads addr 1 with lock=1 while master 0 requests, then writes addr 1 with lock=0 -> both master-1 transfers complete before master 0 is granted.
